hyper_ddr_rx_pack: RTL
======================

Name: hyper_ddr_rx_pack

Overview:
- Receive-side companion of the SDR-to-DDR output path in the HyperBus controller.
- Takes byte pairs that the pad-side DDR capture has already split into first-edge and second-edge bytes, one pair per clk_i cycle.
- Drops the leading byte on odd byte-address starts, counts the transfer length, and packs the bytes little-endian into 32-bit words.
- Buffers the words in a small FIFO that drives a valid/ready stream toward the uDMA RX channel.
- The HyperBus read stream cannot be stalled, so FIFO overflow is flagged, never back-pressured.

Parameters:
- FIFO_DEPTH, 4, number of 32-bit entries in the output FIFO; power of two, >= 2.
- LEN_W, 16, width of the byte-length input and the remaining-byte counter.
- TIMEOUT_CYC, 1024, idle-beat limit in cycles; used only when the optional feature is enabled.

Ports:
- clk_i  in  1  system clock; the only clock in the block.
- rst_ni  in  1  reset, synchronous, active-low.
- start_i  in  1  one-cycle pulse that starts a transaction; ignored unless the block is in IDLE.
- len_i  in  LEN_W  bytes to deliver; sampled on start_i.
- odd_i  in  1  start byte address is odd; sampled on start_i.
- ddr_valid_i  in  1  a captured byte pair is present this cycle.
- ddr_d0_i  in  8  first-edge (earlier) byte of the pair.
- ddr_d1_i  in  8  second-edge (later) byte of the pair.
- data_o  out  32  packed word; byte 0 in [7:0].
- strb_o  out  4  valid-byte mask for data_o.
- last_o  out  1  data_o is the final word of the transaction.
- valid_o  out  1  FIFO head is valid.
- ready_i  in  1  consumer accepts the head word when valid_o && ready_i.
- busy_o  out  1  state is not IDLE.
- done_o  out  1  one-cycle pulse on return to IDLE.
- overflow_o  out  1  sticky flag: a word was lost because the FIFO was full.

Behaviour:
- Reset (rst_ni low at a clk_i edge) clears everything, including mid-transaction:
  - state to IDLE, FIFO emptied, accumulator count to 0.
  - data_o = 0, strb_o = 0, last_o = 0, valid_o = 0, busy_o = 0, done_o = 0, overflow_o = 0.
- States: IDLE, RECV, FLUSH, DRAIN.
- IDLE:
  - start_i with len_i != 0: latch remaining = len_i and skip = odd_i, clear overflow_o, go to RECV.
  - start_i with len_i == 0: stay in IDLE, pulse done_o the next cycle, push no words.
- RECV, per beat where ddr_valid_i = 1:
  - Byte order is d0 then d1.
  - If skip = 1: discard d0 and clear skip.
  - Accept at most `remaining` bytes; bytes beyond the length are discarded.
  - remaining decrements by the number of accepted bytes (0, 1 or 2).
- Accumulator:
  - Holds 0–3 bytes; one beat adds 1 or 2.
  - When the total reaches 4 or more, the low 4 bytes are pushed as a full word (strb 4'hF) and the excess (at most 1 byte) is carried over.
  - At most one push per cycle.
- End of a RECV beat that brings remaining to 0:
  - If after any full-word push the accumulator is empty, the pushed word carries last = 1; go to DRAIN.
  - Otherwise go to FLUSH. FLUSH pushes the partial word next cycle: zero-filled upper bytes, strb = (1 << count) - 1, last = 1. Then go to DRAIN.
  - ddr_valid_i is ignored in FLUSH, DRAIN and IDLE.
- DRAIN: wait until the FIFO is empty, then go to IDLE with done_o high for one cycle.
- Latency: a word completed by the beat in cycle N appears on data_o/valid_o in cycle N+1, assuming the FIFO was empty.
- FIFO:
  - Synchronous, FIFO_DEPTH entries; data_o/strb_o/last_o always reflect the head.
  - Push and pop in the same cycle are allowed, including when full.
- Overflow: a push while the FIFO is full and no pop occurs that cycle drops the word and sets overflow_o. The transaction continues and overflow_o stays set until the next accepted start_i.
- start_i while busy_o = 1: ignored, with no state change.

Optional Feature:
- Macro: HYPER_RX_TIMEOUT_EN.
- When defined:
  - A counter in RECV counts cycles since the last ddr_valid_i (or since entry to RECV).
  - Reaching TIMEOUT_CYC aborts the transaction: any partial accumulator content is pushed with last = 1, then the block goes to DRAIN.
  - Adds output timeout_o (1 bit), sticky until the next accepted start_i.
- When not defined: no counter and no timeout_o port; RECV waits indefinitely.

Test Plan:
- Length 8, even start, beats {01,02},{03,04},{05,06},{07,08}, ready_i = 1 -> words 0x04030201 (strb F, last 0) and 0x08070605 (strb F, last 1); one done_o pulse.
- Length 5, odd start, beats {AA,11},{22,33},{44,55},{66,77} -> AA dropped; words 0x44332211 (strb F) and 0x00000055 (strb 1, last 1); bytes 66/77 discarded.
- Length 3, beats {10,20},{30,40} -> single word 0x00302010, strb 7, last 1 (via FLUSH).
- FIFO_DEPTH = 4, ready_i = 0, length 24 -> 4 words held, 5th and 6th dropped, overflow_o = 1; after ready_i = 1, DRAIN empties and done_o pulses.
- rst_ni low for one cycle mid-RECV with 2 words buffered -> next cycle valid_o = 0, busy_o = 0, overflow_o = 0; a new start_i with length 4 works normally.
- HYPER_RX_TIMEOUT_EN, TIMEOUT_CYC = 16, length 8, a single beat {01,02} then silence -> after 16 idle cycles word 0x00000201, strb 3, last 1; timeout_o = 1; done_o pulses.

Source files
------------

// File: rtl/hyper_ddr_rx_pack_if.sv
// Word stream from the HyperBus RX packer toward the uDMA RX channel.
// The packer drives the word side; the consumer answers with ready.
interface hyper_ddr_rx_pack_if;
  logic [31:0] data_o;
  logic [3:0]  strb_o;
  logic        last_o;
  logic        valid_o;
  logic        ready_i;

  modport master (output data_o, strb_o, last_o, valid_o, input ready_i);
  modport slave  (input data_o, strb_o, last_o, valid_o, output ready_i);
endinterface

// File: rtl/hyper_ddr_rx_pack.sv
// HyperBus RX byte-pair packer: drops odd-start byte, counts length, packs into a word FIFO.
// Optional idle-beat abort is enabled by defining HYPER_RX_TIMEOUT_EN.
module hyper_ddr_rx_pack #(
  parameter int FIFO_DEPTH  = 4,
  parameter int LEN_W       = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic [LEN_W-1:0]         len_i,
  input  logic                     odd_i,
  input  logic                     ddr_valid_i,
  input  logic [7:0]               ddr_d0_i,
  input  logic [7:0]               ddr_d1_i,
  hyper_ddr_rx_pack_if.master      rx,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     overflow_o
`ifdef HYPER_RX_TIMEOUT_EN
  ,
  output logic                     timeout_o
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_FLUSH, S_DRAIN} state_e;

  typedef struct packed {
    logic        last;
    logic [3:0]  strb;
    logic [31:0] data;
  } word_t;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               skip_q, skip_d;
  logic [23:0]        acc_q, acc_d;
  logic [1:0]         acc_cnt_q, acc_cnt_d;
  logic               done_q, done_d;
  logic               ovf_q, ovf_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  word_t              mem [FIFO_DEPTH];

  logic               push, wr_en, pop, full, fifo_valid;
  word_t              push_word, head;
  logic [15:0]        beat_bytes;
  logic [1:0]         avail, n_acc;
  logic [2:0]         total;
  logic [39:0]        merged;

`ifdef HYPER_RX_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic               tmo_q, tmo_d;
`endif

  assign fifo_valid = (fifo_cnt_q != '0);
  assign full       = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign pop        = fifo_valid && rx.ready_i;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    skip_d     = skip_q;
    acc_d      = acc_q;
    acc_cnt_d  = acc_cnt_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    push       = 1'b0;
    push_word  = '0;
    beat_bytes = '0;
    avail      = 2'd0;
    n_acc      = 2'd0;
    total      = 3'd0;
    merged     = '0;
`ifdef HYPER_RX_TIMEOUT_EN
    tmo_cnt_d  = tmo_cnt_q;
    tmo_d      = tmo_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            rem_d     = len_i;
            skip_d    = odd_i;
            acc_d     = '0;
            acc_cnt_d = 2'd0;
            ovf_d     = 1'b0;
            state_d   = S_RECV;
`ifdef HYPER_RX_TIMEOUT_EN
            tmo_cnt_d = '0;
            tmo_d     = 1'b0;
`endif
          end else begin
            done_d = 1'b1;
          end
        end
      end

      S_RECV: begin
        if (ddr_valid_i) begin
          if (skip_q) begin
            beat_bytes = {8'h00, ddr_d1_i};
            avail      = 2'd1;
            skip_d     = 1'b0;
          end else begin
            beat_bytes = {ddr_d1_i, ddr_d0_i};
            avail      = 2'd2;
          end
          n_acc = (rem_q < LEN_W'(avail)) ? rem_q[1:0] : avail;
          // Bytes past the requested length never reach the accumulator.
          if (n_acc == 2'd1) beat_bytes[15:8] = 8'h00;
          if (n_acc == 2'd0) beat_bytes = '0;
          merged = {16'h0000, acc_q} | ({24'h000000, beat_bytes} << {acc_cnt_q, 3'b000});
          total  = {1'b0, acc_cnt_q} + {1'b0, n_acc};
          if (total >= 3'd4) begin
            push      = 1'b1;
            push_word = '{last: 1'b0, strb: 4'hF, data: merged[31:0]};
            acc_d     = {16'h0000, merged[39:32]};
            acc_cnt_d = 2'(total - 3'd4);
          end else begin
            acc_d     = merged[23:0];
            acc_cnt_d = total[1:0];
          end
          rem_d = rem_q - LEN_W'(n_acc);
          if (rem_d == '0) begin
            if (acc_cnt_d == 2'd0) begin
              push_word.last = 1'b1;
              state_d        = S_DRAIN;
            end else begin
              state_d = S_FLUSH;
            end
          end
        end
`ifdef HYPER_RX_TIMEOUT_EN
        if (ddr_valid_i) begin
          tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          tmo_d   = 1'b1;
          state_d = (acc_cnt_q != 2'd0) ? S_FLUSH : S_DRAIN;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
`endif
      end

      S_FLUSH: begin
        push      = 1'b1;
        push_word = '{last: 1'b1, strb: 4'((5'd1 << acc_cnt_q) - 5'd1), data: {8'h00, acc_q}};
        acc_d     = '0;
        acc_cnt_d = 2'd0;
        state_d   = S_DRAIN;
      end

      S_DRAIN: begin
        if (!fifo_valid) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // The read stream cannot stall, so a full FIFO without a pop loses the word.
    wr_en = push && (!full || pop);
    if (push && full && !pop) ovf_d = 1'b1;

    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    fifo_cnt_d = fifo_cnt_q + CNT_W'(wr_en) - CNT_W'(pop);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      rem_q      <= '0;
      skip_q     <= 1'b0;
      acc_q      <= '0;
      acc_cnt_q  <= 2'd0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
`ifdef HYPER_RX_TIMEOUT_EN
      tmo_cnt_q  <= '0;
      tmo_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      skip_q     <= skip_d;
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
`ifdef HYPER_RX_TIMEOUT_EN
      tmo_cnt_q  <= tmo_cnt_d;
      tmo_q      <= tmo_d;
`endif
    end
  end

  // NOTE: the storage array is not reset; reset empties the pointers and the outputs are gated by valid.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_ptr_q] <= push_word;
  end

  assign head       = mem[rd_ptr_q];
  assign rx.valid_o = fifo_valid;
  assign rx.data_o  = fifo_valid ? head.data : 32'h0;
  assign rx.strb_o  = fifo_valid ? head.strb : 4'h0;
  assign rx.last_o  = fifo_valid ? head.last : 1'b0;

  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = done_q;
  assign overflow_o = ovf_q;
`ifdef HYPER_RX_TIMEOUT_EN
  assign timeout_o  = tmo_q;
`endif

endmodule
